// File: rtl/dekatron_counter_sequencer_if.sv
// Client command/response bus and counter step bus of dekatron_counter_sequencer.
// slave = the sequencer; master = requesters plus the counter.
interface dekatron_counter_sequencer_if #(
  parameter int D_NUM = 3,
  parameter int CNT_W = 8
);
  localparam int DW = D_NUM * 4;

  logic [1:0]            ReqValid;
  logic [1:0][1:0]       ReqOp;
  logic [1:0][CNT_W-1:0] ReqCount;
  logic [1:0][DW-1:0]    ReqData;
  logic [1:0]            ReqAck;
  logic [1:0]            Done;
  logic                  Underflow;
  logic [DW-1:0]         Result;
  logic                  Busy;
  logic                  CntRequest;
  logic                  CntDec;
  logic                  CntSet;
  logic [DW-1:0]         CntIn;
  logic                  CntReady;
  logic [DW-1:0]         CntOut;

  modport slave (
    input  ReqValid, ReqOp, ReqCount, ReqData, CntReady, CntOut,
    output ReqAck, Done, Underflow, Result, Busy, CntRequest, CntDec, CntSet, CntIn
  );

  modport master (
    output ReqValid, ReqOp, ReqCount, ReqData, CntReady, CntOut,
    input  ReqAck, Done, Underflow, Result, Busy, CntRequest, CntDec, CntSet, CntIn
  );
endinterface

// File: rtl/dekatron_counter_sequencer.sv
// Round-robin sequencer turning INC/DEC xN and SET commands into single counter steps.
// Define DEKATRON_SEQ_ZERO_STOP_EN to truncate a DEC when the counter reaches zero.
module dekatron_counter_sequencer #(
  parameter int D_NUM = 3,
  parameter int CNT_W = 8
) (
  input logic                         Clk,
  input logic                         Rst_n,
  dekatron_counter_sequencer_if.slave bus
);
  localparam int DW = D_NUM * 4;
  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_ISSUE  = 3'd2,
    S_SETTLE = 3'd3,
    S_WAIT   = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             grant_q, grant_d;
  logic [1:0]       op_q, op_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       done_q, done_d;
  logic [DW-1:0]    result_q, result_d;
  logic             busy_q, busy_d;
  logic             req_q, req_d;
  logic             dec_q, dec_d;
  logic             set_q, set_d;
  logic [DW-1:0]    cin_q, cin_d;
  logic [1:0]       acc_op_s;
  logic [CNT_W-1:0] acc_cnt_s;
  logic             stop_s;
`ifdef DEKATRON_SEQ_ZERO_STOP_EN
  logic             uf_q, uf_d;
  logic             undf_q, undf_d;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    op_d      = op_q;
    data_d    = data_q;
    rem_d     = rem_q;
    ack_d     = 2'b00;
    done_d    = 2'b00;
    result_d  = result_q;
    req_d     = 1'b0;
    dec_d     = 1'b0;
    set_d     = 1'b0;
    cin_d     = {DW{1'b0}};
    acc_op_s  = bus.ReqOp[grant_q];
    acc_cnt_s = bus.ReqCount[grant_q];
`ifdef DEKATRON_SEQ_ZERO_STOP_EN
    uf_d      = uf_q;
    undf_d    = 1'b0;
    stop_s    = (op_q == OP_DEC) && (bus.CntOut == {DW{1'b0}});
`else
    stop_s    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.ReqValid != 2'b00) begin
          // On a tie the client that was not granted last wins; ptr tracks the last grant.
          grant_d = bus.ReqValid[1] & (~bus.ReqValid[0] | ~ptr_q);
          ptr_d   = grant_d;
          state_d = S_ACCEPT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCEPT: begin
        ack_d[grant_q] = 1'b1;
        op_d           = acc_op_s;
        data_d         = bus.ReqData[grant_q];
`ifdef DEKATRON_SEQ_ZERO_STOP_EN
        uf_d           = 1'b0;
`endif
        if ((acc_op_s == OP_NOP) || ((acc_op_s != OP_SET) && (acc_cnt_s == {CNT_W{1'b0}}))) begin
          rem_d   = {CNT_W{1'b0}};
          state_d = S_FINISH;
        end else if (acc_op_s == OP_SET) begin
          rem_d   = CNT_W'(1);
          state_d = S_ISSUE;
        end else begin
          rem_d   = acc_cnt_s;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.CntReady) begin
          if (stop_s) begin
`ifdef DEKATRON_SEQ_ZERO_STOP_EN
            uf_d = 1'b1;
`endif
            state_d = S_FINISH;
          end else begin
            req_d   = 1'b1;
            dec_d   = (op_q == OP_DEC);
            set_d   = (op_q == OP_SET);
            cin_d   = (op_q == OP_SET) ? data_q : {DW{1'b0}};
            rem_d   = (rem_q != {CNT_W{1'b0}}) ? (rem_q - CNT_W'(1)) : rem_q;
            state_d = S_SETTLE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      // The counter drops Ready a cycle after it sees the step, so Ready is not trusted here.
      S_SETTLE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.CntReady) begin
          state_d = (rem_q == {CNT_W{1'b0}}) ? S_FINISH : S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FINISH: begin
        result_d        = bus.CntOut;
        done_d[grant_q] = 1'b1;
`ifdef DEKATRON_SEQ_ZERO_STOP_EN
        undf_d          = uf_q;
`endif
        state_d         = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ptr_q    <= 1'b1;
      grant_q  <= 1'b0;
      op_q     <= 2'b00;
      data_q   <= {DW{1'b0}};
      rem_q    <= {CNT_W{1'b0}};
      ack_q    <= 2'b00;
      done_q   <= 2'b00;
      result_q <= {DW{1'b0}};
      busy_q   <= 1'b0;
      req_q    <= 1'b0;
      dec_q    <= 1'b0;
      set_q    <= 1'b0;
      cin_q    <= {DW{1'b0}};
`ifdef DEKATRON_SEQ_ZERO_STOP_EN
      uf_q     <= 1'b0;
      undf_q   <= 1'b0;
`endif
    end else begin
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      op_q     <= op_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      req_q    <= req_d;
      dec_q    <= dec_d;
      set_q    <= set_d;
      cin_q    <= cin_d;
`ifdef DEKATRON_SEQ_ZERO_STOP_EN
      uf_q     <= uf_d;
      undf_q   <= undf_d;
`endif
    end
  end

  assign bus.ReqAck     = ack_q;
  assign bus.Done       = done_q;
  assign bus.Result     = result_q;
  assign bus.Busy       = busy_q;
  assign bus.CntRequest = req_q;
  assign bus.CntDec     = dec_q;
  assign bus.CntSet     = set_q;
  assign bus.CntIn      = cin_q;
`ifdef DEKATRON_SEQ_ZERO_STOP_EN
  assign bus.Underflow  = undf_q;
`else
  assign bus.Underflow  = 1'b0;
`endif

endmodule
